// File: rtl/mmio_lock_responder.sv
// rtl/mmio_lock_responder.sv - memory-mapped lock servo responder with slewed PWM and lock status
module mmio_lock_responder #(
    parameter logic [11:0] BASE_ADDR      = 12'hF00,
    parameter int unsigned PERIOD_TICKS   = 1000000,
    parameter int unsigned PULSE_LOCK     = 50000,
    parameter int unsigned PULSE_UNLOCK   = 100000,
    parameter int unsigned STEP           = 2500,
    parameter int unsigned SETTLE_PERIODS = 25
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wren,
    input  logic [31:0] address_dmem,
    input  logic [31:0] data,
    output logic [31:0] q_dmem,
    output logic        rd_hit,
    input  logic        lock_sensor,
    output logic        servo_pwm
);

    localparam logic [2:0] ST_LOCKED    = 3'd0;
    localparam logic [2:0] ST_UNLOCKING = 3'd1;
    localparam logic [2:0] ST_UNLOCKED  = 3'd2;
    localparam logic [2:0] ST_LOCKING   = 3'd3;
    localparam logic [2:0] ST_FAULT     = 3'd4;

    localparam logic [31:0] P_PERIOD = 32'(PERIOD_TICKS);
    localparam logic [31:0] P_LAST   = 32'(PERIOD_TICKS - 1);
    localparam logic [31:0] P_LOCK   = 32'(PULSE_LOCK);
    localparam logic [31:0] P_UNLOCK = 32'(PULSE_UNLOCK);
    localparam logic [31:0] P_STEP   = 32'(STEP);
    localparam logic [31:0] P_SETTLE = 32'(SETTLE_PERIODS);

    logic [2:0]  state_q, state_d;
    logic [31:0] pulse_q, pulse_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] settle_q, settle_d;
    logic [31:0] q_dmem_q, q_dmem_d;
    logic        rd_hit_q, rd_hit_d;
    logic        pwm_q, pwm_d;
    logic        sync1_q, sync1_d;
    logic        sens_q, sens_d;

    logic [11:0] offset;
    logic        in_window;
    logic        cmd_wr;
    logic        cmd_unlock, cmd_lock, cmd_clear;
    logic        wrap;
    logic        busy;
    logic [31:0] pulse_inc, pulse_dec;
    logic        unused_addr_hi;

    assign offset     = address_dmem[11:0] - BASE_ADDR;
    assign in_window  = offset < 12'd4;
    assign cmd_wr     = wren && (offset == 12'd0);
    assign cmd_unlock = cmd_wr && (data == 32'd1);
    assign cmd_lock   = cmd_wr && (data == 32'd2);
    assign cmd_clear  = cmd_wr && (data == 32'd3);
    assign wrap       = cnt_q == P_LAST;
    assign busy       = (state_q == ST_UNLOCKING) || (state_q == ST_LOCKING);
    assign unused_addr_hi = ^address_dmem[31:12];

    // Saturate by comparing before the add/subtract so the pulse never overshoots or wraps.
    assign pulse_inc = (pulse_q >= P_UNLOCK - P_STEP) ? P_UNLOCK : pulse_q + P_STEP;
    assign pulse_dec = (pulse_q <= P_LOCK + P_STEP) ? P_LOCK : pulse_q - P_STEP;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_LOCKED;
            pulse_q  <= P_LOCK;
            cnt_q    <= 32'd0;
            settle_q <= 32'd0;
            q_dmem_q <= 32'd0;
            rd_hit_q <= 1'b0;
            pwm_q    <= 1'b0;
            sync1_q  <= 1'b0;
            sens_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pulse_q  <= pulse_d;
            cnt_q    <= cnt_d;
            settle_q <= settle_d;
            q_dmem_q <= q_dmem_d;
            rd_hit_q <= rd_hit_d;
            pwm_q    <= pwm_d;
            sync1_q  <= sync1_d;
            sens_q   <= sens_d;
        end
    end

    // Pulse only moves on the wrap cycle, so every emitted period has a single clean width.
    always_comb begin
        state_d  = state_q;
        pulse_d  = pulse_q;
        settle_d = settle_q;
        if (wrap) begin
            if (state_q == ST_UNLOCKING) begin
                pulse_d = pulse_inc;
            end else if (state_q == ST_LOCKING) begin
                pulse_d = pulse_dec;
            end
        end
        case (state_q)
            ST_LOCKED: begin
                if (cmd_unlock) begin
                    state_d = ST_UNLOCKING;
                end
            end
            ST_UNLOCKING: begin
                if (cmd_lock) begin
                    state_d  = ST_LOCKING;
                    settle_d = 32'd0;
                end else if (pulse_d == P_UNLOCK) begin
                    state_d = ST_UNLOCKED;
                end
            end
            ST_UNLOCKED: begin
                if (cmd_lock) begin
                    state_d  = ST_LOCKING;
                    settle_d = 32'd0;
                end
            end
            ST_LOCKING: begin
                if (cmd_unlock) begin
                    state_d = ST_UNLOCKING;
                end else if ((pulse_d == P_LOCK) && sens_q) begin
                    state_d  = ST_LOCKED;
                    settle_d = 32'd0;
                end else if (wrap && (pulse_q == P_LOCK)) begin
                    settle_d = settle_q + 32'd1;
                    if (settle_d == P_SETTLE) begin
                        state_d = ST_FAULT;
                    end
                end
            end
            ST_FAULT: begin
                if (cmd_clear) begin
                    state_d  = ST_LOCKING;
                    settle_d = 32'd0;
                end
            end
            default: begin
                state_d = ST_LOCKED;
                pulse_d = P_LOCK;
            end
        endcase
    end

    always_comb begin
        sync1_d  = lock_sensor;
        sens_d   = sync1_q;
        cnt_d    = wrap ? 32'd0 : cnt_q + 32'd1;
        pwm_d    = cnt_q < pulse_q;
        rd_hit_d = in_window;
        q_dmem_d = 32'd0;
        if (in_window) begin
            case (offset[1:0])
                2'd0:    q_dmem_d = {29'd0, state_q};
                2'd1:    q_dmem_d = {28'd0, state_q == ST_FAULT, sens_q, busy, state_q == ST_LOCKED};
                2'd2:    q_dmem_d = pulse_q;
                default: q_dmem_d = P_PERIOD;
            endcase
        end
    end

    assign q_dmem    = q_dmem_q;
    assign rd_hit    = rd_hit_q;
    assign servo_pwm = pwm_q;

endmodule

// File: tb/tb_mmio_lock_responder.sv
// tb/tb_mmio_lock_responder.sv - scoreboard bench for mmio_lock_responder
module tb_mmio_lock_responder;

    localparam int PERIOD = 100;
    localparam int LOCK   = 10;
    localparam int UNLOCK = 20;
    localparam int STEP   = 5;
    localparam int SETTLE = 3;
    localparam logic [11:0] BASE = 12'hF00;

    logic        clock = 1'b0;
    logic        reset;
    logic        wren;
    logic [31:0] address_dmem;
    logic [31:0] data;
    logic [31:0] q_dmem;
    logic        rd_hit;
    logic        lock_sensor;
    logic        servo_pwm;

    always #5 clock = ~clock;

    mmio_lock_responder #(
        .BASE_ADDR(BASE),
        .PERIOD_TICKS(PERIOD),
        .PULSE_LOCK(LOCK),
        .PULSE_UNLOCK(UNLOCK),
        .STEP(STEP),
        .SETTLE_PERIODS(SETTLE)
    ) dut (
        .clock(clock),
        .reset(reset),
        .wren(wren),
        .address_dmem(address_dmem),
        .data(data),
        .q_dmem(q_dmem),
        .rd_hit(rd_hit),
        .lock_sensor(lock_sensor),
        .servo_pwm(servo_pwm)
    );

    typedef struct {
        bit          hit;
        logic [31:0] val;
    } rd_exp_t;

    int      checks = 0;
    int      passed = 0;
    bit      rd_req = 1'b0;
    bit      mon_en = 1'b0;
    rd_exp_t rd_q[$];
    int      pwm_q[$];

    // Reference model: lock mechanism in plain integer terms.
    int m_state, m_pulse, m_cnt, m_settle;
    bit m_s1, m_sens;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic rd_exp_t model_read(input logic [31:0] addr);
        rd_exp_t    r;
        logic [11:0] off;
        off   = addr[11:0] - BASE;
        r.hit = (off < 12'd4);
        r.val = 32'd0;
        if (r.hit) begin
            case (off)
                12'd0: r.val = 32'(m_state);
                12'd1: r.val = 32'((m_state == 0 ? 1 : 0) + ((m_state == 1 || m_state == 3) ? 2 : 0)
                                   + (m_sens ? 4 : 0) + (m_state == 4 ? 8 : 0));
                12'd2: r.val = 32'(m_pulse);
                default: r.val = 32'(PERIOD);
            endcase
        end
        return r;
    endfunction

    function automatic void model_update();
        int cmd, np, ns;
        bit at_end;
        if (reset) begin
            m_state = 0; m_pulse = LOCK; m_cnt = 0; m_settle = 0; m_s1 = 0; m_sens = 0;
            pwm_q.delete();
            pwm_q.push_back(LOCK);
            return;
        end
        cmd = 0;
        if (wren && address_dmem[11:0] == BASE && data >= 1 && data <= 3) cmd = int'(data);
        at_end = (m_cnt == PERIOD - 1);
        np = m_pulse;
        if (at_end && m_state == 1) np = (m_pulse + STEP > UNLOCK) ? UNLOCK : m_pulse + STEP;
        if (at_end && m_state == 3) np = (m_pulse - STEP < LOCK) ? LOCK : m_pulse - STEP;
        ns = m_state;
        if (m_state == 0 && cmd == 1) ns = 1;
        else if ((m_state == 1 || m_state == 2) && cmd == 2) begin ns = 3; m_settle = 0; end
        else if (m_state == 1 && np == UNLOCK) ns = 2;
        else if (m_state == 3 && cmd == 1) ns = 1;
        else if (m_state == 3 && np == LOCK && m_sens) begin ns = 0; m_settle = 0; end
        else if (m_state == 3 && at_end && m_pulse == LOCK) begin
            m_settle++;
            if (m_settle == SETTLE) ns = 4;
        end
        else if (m_state == 4 && cmd == 3) begin ns = 3; m_settle = 0; end
        m_state = ns;
        m_pulse = np;
        m_cnt   = at_end ? 0 : m_cnt + 1;
        if (m_cnt == 0) pwm_q.push_back(m_pulse);
        m_sens = m_s1;
        m_s1   = lock_sensor;
    endfunction

    task automatic tick();
        rd_exp_t e;
        if (rd_req) begin
            if (reset) begin e.hit = 1'b0; e.val = 32'd0; end
            else e = model_read(address_dmem);
            rd_q.push_back(e);
        end
        @(posedge clock);
        model_update();
        @(negedge clock);
        reset = 1'b0; wren = 1'b0; rd_req = 1'b0;
        address_dmem = 32'd0; data = $urandom;
    endtask

    task automatic load(input logic [11:0] a);
        address_dmem = ($urandom & 32'hFFFF_F000) | {20'd0, a};
        rd_req = 1'b1;
        tick();
    endtask

    task automatic store(input logic [11:0] a, input logic [31:0] v);
        address_dmem = {20'd0, a}; data = v; wren = 1'b1; rd_req = 1'b1;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 7) == 0) load(BASE + 12'($urandom_range(0, 3)));
            else tick();
        end
    endtask

    task automatic wait_state(input int s, input int budget, input string name);
        int n = 0;
        while (m_state != s && n < budget) begin idle(1); n++; end
        checks++;
        if (m_state == s) passed++;
        else $display("FAIL %s: timeout state %0d expected %0d", name, m_state, s);
    endtask

    initial begin : read_monitor
        bit issued;
        rd_exp_t e;
        wait (mon_en);
        forever begin
            @(posedge clock);
            issued = rd_req;
            @(negedge clock);
            if (issued || rd_hit) begin
                if (rd_q.size() == 0) begin
                    checks++;
                    $display("FAIL rd_unexpected: got rd_hit=%0d q=0x%0h expected no read", rd_hit, q_dmem);
                end else begin
                    e = rd_q.pop_front();
                    check("rd_hit", {31'd0, rd_hit}, {31'd0, e.hit});
                    check("q_dmem", q_dmem, e.val);
                end
            end
        end
    end

    initial begin : pwm_monitor
        int run = 0;
        wait (mon_en);
        forever begin
            @(negedge clock);
            if (servo_pwm) run++;
            else if (run > 0) begin
                if (pwm_q.size() == 0) begin
                    checks++;
                    $display("FAIL pwm_unexpected: got high time %0d expected none", run);
                end else check("pwm_high", 32'(run), 32'(pwm_q.pop_front()));
                run = 0;
            end
        end
    end

    initial begin
        int r;
        reset = 1'b1; wren = 1'b0; address_dmem = 32'd0; data = 32'd0; lock_sensor = 1'b0;
        for (int i = 0; i < 3; i++) begin reset = 1'b1; tick(); end
        mon_en = 1'b1;

        load(12'hF01);
        idle(250);

        store(12'hF00, 32'd1);
        wait_state(2, 400, "to_unlocked");
        load(12'hF00); load(12'hF01); load(12'hF02); load(12'hF03);

        lock_sensor = 1'b1;
        idle(5);
        store(12'hF00, 32'd2);
        wait_state(0, 400, "lock_with_sensor");
        load(12'hF01);

        lock_sensor = 1'b0;
        store(12'hF00, 32'd1);
        wait_state(2, 400, "unlock_again");
        store(12'hF00, 32'd2);
        wait_state(4, 1000, "to_fault");
        load(12'hF01);
        store(12'hF00, 32'd1);
        idle(150);
        load(12'hF00);
        store(12'hF00, 32'd3);
        idle(20);
        lock_sensor = 1'b1;
        wait_state(0, 400, "fault_clear_lock");
        load(12'hF01);

        store(12'hF00, 32'd1);
        for (int n = 0; n < 300 && m_pulse != 15; n++) idle(1);
        store(12'hF00, 32'd2);
        wait_state(0, 400, "reverse_lock");
        idle(200);

        load(12'hEFF); load(12'hF04);
        store(12'hF00, 32'd7); load(12'hF00);
        store(12'hF02, 32'd55); load(12'hF02);
        store(12'hF00, 32'd1);
        for (int n = 0; n < 300 && !(m_state == 1 && m_cnt == 50 && m_pulse == 15); n++) tick();
        reset = 1'b1;
        tick();
        load(12'hF00); load(12'hF02);

        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 15);
            if (r == 0) store(BASE, 32'($urandom_range(0, 4)));
            else if (r < 4) load(12'hEFF + 12'($urandom_range(0, 5)));
            else begin
                if (r == 4) lock_sensor = 1'($urandom_range(0, 1));
                tick();
            end
        end
        idle(5);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
